// File: rtl/alu2_wb_pkg.sv
// rtl/alu2_wb_pkg.sv - shared constants for the ALU writeback stage
package alu2_wb_pkg;

    localparam int FLAG_W = 8;

endpackage

// File: rtl/alu2_flagreg.sv
// rtl/alu2_flagreg.sv - architectural flag register with load priority
// Optional same-cycle bypass of in_fo onto flags: ALU2_WB_FLAG_BYPASS_EN.
module alu2_flagreg
    import alu2_wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_ld,
    input  logic [FLAG_W-1:0] flag_ld_val,
    input  logic              fo_we,
    input  logic [FLAG_W-1:0] fo,
    output logic [FLAG_W-1:0] flags
);

    logic [FLAG_W-1:0] flag_q;

    // External load outranks the instruction's own flag write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_q <= '0;
        end else if (flag_ld) begin
            flag_q <= flag_ld_val;
        end else if (fo_we) begin
            flag_q <= fo;
        end
    end

`ifdef ALU2_WB_FLAG_BYPASS_EN
    assign flags = (fo_we && !flag_ld) ? fo : flag_q;
`else
    assign flags = flag_q;
`endif

endmodule

// File: rtl/alu2_wb.sv
// rtl/alu2_wb.sv - execute-to-writeback holding register, flags and retire count
// Optional flag bypass selected by ALU2_WB_FLAG_BYPASS_EN (see alu2_flagreg).
module alu2_wb
    import alu2_wb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int RWIDTH = 4,
    parameter int CWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_res,
    input  logic [FLAG_W-1:0] in_fo,
    input  logic              in_wb_en,
    input  logic              in_flag_en,
    input  logic [RWIDTH-1:0] in_rd,
    output logic              rf_we,
    input  logic              rf_ready,
    output logic [RWIDTH-1:0] rf_wa,
    output logic [WIDTH-1:0]  rf_wd,
    output logic [FLAG_W-1:0] flags,
    input  logic              flag_ld,
    input  logic [FLAG_W-1:0] flag_ld_val,
    output logic              fwd_valid,
    output logic [RWIDTH-1:0] fwd_rd,
    output logic [WIDTH-1:0]  fwd_data,
    output logic [CWIDTH-1:0] retired
);

    logic              acc;
    logic              load;
    logic              rf_we_d;
    logic [RWIDTH-1:0] rf_wa_d;
    logic [WIDTH-1:0]  rf_wd_d;

    assign in_ready = !rf_we || rf_ready;
    assign acc      = in_valid && in_ready;
    assign load     = acc && in_wb_en;

    // rf_we is the whole holding-register state: EMPTY=0, FULL=1.
    always_comb begin
        rf_we_d = rf_we;
        rf_wa_d = rf_wa;
        rf_wd_d = rf_wd;
        if (load) begin
            rf_we_d = 1'b1;
            rf_wa_d = in_rd;
            rf_wd_d = in_res;
        end else if (rf_ready) begin
            rf_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
            retired <= '0;
        end else begin
            rf_we <= rf_we_d;
            rf_wa <= rf_wa_d;
            rf_wd <= rf_wd_d;
            if (acc) begin
                retired <= retired + CWIDTH'(1);
            end
        end
    end

    // A same-cycle acceptance is deliberately not forwarded.
    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_wa;
    assign fwd_data  = rf_wd;

    alu2_flagreg u_flagreg (
        .clk         (clk),
        .reset       (reset),
        .flag_ld     (flag_ld),
        .flag_ld_val (flag_ld_val),
        .fo_we       (acc && in_flag_en),
        .fo          (in_fo),
        .flags       (flags)
    );

endmodule

// File: tb/tb_alu2_wb.sv
// tb/tb_alu2_wb.sv - self-checking bench for alu2_wb with a behavioural model
module tb_alu2_wb;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_res;
    logic [7:0]  in_fo;
    logic        in_wb_en;
    logic        in_flag_en;
    logic [3:0]  in_rd;
    logic        rf_we;
    logic        rf_ready;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [7:0]  flags;
    logic        flag_ld;
    logic [7:0]  flag_ld_val;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] retired;

    logic        w_in_ready;
    logic        w_rf_we;
    logic [3:0]  w_rf_wa;
    logic [31:0] w_rf_wd;
    logic [7:0]  w_flags;
    logic        w_fwd_valid;
    logic [3:0]  w_fwd_rd;
    logic [31:0] w_fwd_data;
    logic [3:0]  w_retired;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_full;
    logic [3:0]  m_rd;
    logic [31:0] m_data;
    logic [7:0]  m_flags;
    logic [31:0] m_retired;

    alu2_wb u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_res(in_res), .in_fo(in_fo), .in_wb_en(in_wb_en), .in_flag_en(in_flag_en),
        .in_rd(in_rd), .rf_we(rf_we), .rf_ready(rf_ready), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .flags(flags), .flag_ld(flag_ld), .flag_ld_val(flag_ld_val),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retired(retired)
    );

    alu2_wb #(.CWIDTH(4)) u_dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_res(in_res), .in_fo(in_fo), .in_wb_en(in_wb_en), .in_flag_en(in_flag_en),
        .in_rd(in_rd), .rf_we(w_rf_we), .rf_ready(rf_ready), .rf_wa(w_rf_wa), .rf_wd(w_rf_wd),
        .flags(w_flags), .flag_ld(flag_ld), .flag_ld_val(flag_ld_val),
        .fwd_valid(w_fwd_valid), .fwd_rd(w_fwd_rd), .fwd_data(w_fwd_data), .retired(w_retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_ready();
        return !m_full || rf_ready;
    endfunction

    function automatic logic [7:0] model_flags_out();
        logic acc;
        acc = in_valid && model_ready();
`ifdef ALU2_WB_FLAG_BYPASS_EN
        if (acc && in_flag_en && !flag_ld) return in_fo;
`endif
        return m_flags;
    endfunction

    // Applies the current inputs to the model, then advances one clock.
    task automatic tick();
        logic acc;
        acc = in_valid && model_ready();
        if (flag_ld) m_flags = flag_ld_val;
        else if (acc && in_flag_en) m_flags = in_fo;
        if (acc) m_retired = m_retired + 1;
        if (acc && in_wb_en) begin
            m_full = 1'b1;
            m_rd   = in_rd;
            m_data = in_res;
        end else if (rf_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [7:0] fo,
                         input logic wb, input logic fe, input logic [3:0] rd,
                         input logic rdy, input logic ld, input logic [7:0] ldv);
        in_valid = v; in_res = res; in_fo = fo; in_wb_en = wb; in_flag_en = fe;
        in_rd = rd; rf_ready = rdy; flag_ld = ld; flag_ld_val = ldv;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 8'hFF, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b exp 0", rf_we); end
        checks++; if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags: got %h exp 00", flags); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %h exp 0", retired); end
        checks++; if ({fwd_valid, rf_wa, rf_wd} !== 37'd0) begin errors++; $display("FAIL reset_rf_port: got %b/%h/%h exp 0", fwd_valid, rf_wa, rf_wd); end
        m_full = 1'b0; m_rd = '0; m_data = '0; m_flags = '0; m_retired = '0;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        drive(1'b1, 32'h1234_5678, 8'h00, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 8'h00);
        tick();
        checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd3, 32'h1234_5678}) begin errors++; $display("FAIL first_acc: got %b/%h/%h exp 1/3/12345678", rf_we, rf_wa, rf_wd); end
        checks++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 4'd3, 32'h1234_5678}) begin errors++; $display("FAIL first_fwd: got %b/%h/%h exp 1/3/12345678", fwd_valid, fwd_rd, fwd_data); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] r0;
        r0 = m_retired;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0BAD_0000 + i, 8'h00, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 8'h00);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b exp 0", in_ready); end
            tick();
            checks++; if ({rf_we, rf_wd} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL stall_rf_wd: got %b/%h exp 1/12345678", rf_we, rf_wd); end
            checks++; if (retired !== r0) begin errors++; $display("FAIL stall_retired: got %h exp %h", retired, r0); end
        end
        drive(1'b1, 32'h0000_00A5, 8'h00, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 8'h00);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
        tick();
        checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd5, 32'h0000_00A5}) begin errors++; $display("FAIL reload: got %b/%h/%h exp 1/5/a5", rf_we, rf_wa, rf_wd); end
        checks++; if (retired !== r0 + 1) begin errors++; $display("FAIL reload_retired: got %h exp %h", retired, r0 + 1); end
    endtask

    task automatic test_flag_only();
        logic [31:0] r0;
        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00);
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL drain_rf_we: got %b exp 0", rf_we); end
        r0 = m_retired;
        drive(1'b1, 32'h5555_5555, 8'h03, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 8'h00);
        tick();
        checks++; if (flags !== 8'h03) begin errors++; $display("FAIL flag_only_flags: got %h exp 03", flags); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flag_only_rf_we: got %b exp 0", rf_we); end
        checks++; if (retired !== r0 + 1) begin errors++; $display("FAIL flag_only_retired: got %h exp %h", retired, r0 + 1); end
    endtask

    task automatic test_priority();
        drive(1'b1, 32'h0000_0077, 8'h01, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 8'hF0);
        checks++; if (flags !== 8'h03) begin errors++; $display("FAIL prio_comb_flags: got %h exp 03", flags); end
        tick();
        checks++; if (flags !== 8'hF0) begin errors++; $display("FAIL prio_flags: got %h exp f0", flags); end
        checks++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd6, 32'h0000_0077}) begin errors++; $display("FAIL prio_write: got %b/%h/%h exp 1/6/77", rf_we, rf_wa, rf_wd); end
    endtask

    task automatic test_bypass();
        logic [7:0] exp_now;
`ifdef ALU2_WB_FLAG_BYPASS_EN
        exp_now = 8'h01;
`else
        exp_now = 8'hF0;
`endif
        drive(1'b1, 32'h0, 8'h01, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 8'h00);
        checks++; if (flags !== exp_now) begin errors++; $display("FAIL bypass_same_cycle: got %h exp %h", flags, exp_now); end
        tick();
        checks++; if (flags !== 8'h01) begin errors++; $display("FAIL bypass_next_cycle: got %h exp 01", flags); end
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        drive(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00);
        while (m_retired[3:0] != 4'hF && guard < 32) begin
            tick();
            guard++;
        end
        checks++; if (w_retired !== 4'hF) begin errors++; $display("FAIL wrap_pre: got %h exp f", w_retired); end
        tick();
        checks++; if (w_retired !== 4'h0) begin errors++; $display("FAIL wrap_zero: got %h exp 0", w_retired); end
        checks++; if (retired !== m_retired) begin errors++; $display("FAIL wrap_wide: got %h exp %h", retired, m_retired); end
    endtask

    task automatic test_random();
        logic [7:0] ef;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0, 8'($urandom));
            ef = model_flags_out();
            checks++; if (in_ready !== model_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b exp %b", i, in_ready, model_ready()); end
            checks++; if (flags !== ef) begin errors++; $display("FAIL rnd_flags_comb[%0d]: got %h exp %h", i, flags, ef); end
            tick();
            checks++; if ({rf_we, rf_wa, rf_wd} !== {m_full, m_rd, m_data}) begin errors++; $display("FAIL rnd_rf[%0d]: got %b/%h/%h exp %b/%h/%h", i, rf_we, rf_wa, rf_wd, m_full, m_rd, m_data); end
            checks++; if ({fwd_valid, fwd_rd, fwd_data} !== {m_full, m_rd, m_data}) begin errors++; $display("FAIL rnd_fwd[%0d]: got %b/%h/%h exp %b/%h/%h", i, fwd_valid, fwd_rd, fwd_data, m_full, m_rd, m_data); end
            checks++; if (retired !== m_retired) begin errors++; $display("FAIL rnd_retired[%0d]: got %h exp %h", i, retired, m_retired); end
            checks++; if (w_retired !== m_retired[3:0]) begin errors++; $display("FAIL rnd_retired_w[%0d]: got %h exp %h", i, w_retired, m_retired[3:0]); end
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 32'hCAFE_0001, 8'h00, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL stall_reset_rf_we: got %b exp 0", rf_we); end
        m_full = 1'b0; m_rd = '0; m_data = '0; m_flags = '0; m_retired = '0;
        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        checks++; if ({rf_we, retired} !== {1'b0, 32'd0}) begin errors++; $display("FAIL stall_reset_idle: got %b/%h exp 0/0", rf_we, retired); end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        test_reset();
        test_back_pressure();
        test_flag_only();
        test_priority();
        test_bypass();
        test_wrap();
        test_random();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu2_wb.md
Name: alu2_wb

Overview:
- Execute-to-writeback stage directly downstream of the cpu2 ALU.
- Captures the ALU result, flag vector, wb_en, flag_en and destination register index into a single-entry holding register.
- Drives the register-file write port with a valid/ready handshake and owns the architectural flag register that feeds the ALU fi input.
- Provides forwarding info for the pending write and a retired-instruction counter.

Parameters:
- WIDTH, 32, datapath width of the result and register-file data.
- RWIDTH, 4, register index width (16 registers).
- CWIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU outputs and in_rd are valid this cycle.
- in_ready  out  1  stage accepts the input this cycle.
- in_res  in  WIDTH  ALU result.
- in_fo  in  8  ALU flag vector.
- in_wb_en  in  1  result is to be written to in_rd.
- in_flag_en  in  1  in_fo is to be written to the flag register.
- in_rd  in  RWIDTH  destination register index.
- rf_we  out  1  register-file write request (valid).
- rf_ready  in  1  register file accepts the write this cycle.
- rf_wa  out  RWIDTH  write address.
- rf_wd  out  WIDTH  write data.
- flags  out  8  architectural flag register, connected to the ALU fi.
- flag_ld  in  1  external flag load (interrupt return, debug).
- flag_ld_val  in  8  value for flag_ld.
- fwd_valid  out  1  a write is pending in the holding register.
- fwd_rd  out  RWIDTH  pending destination index.
- fwd_data  out  WIDTH  pending data.
- retired  out  CWIDTH  count of accepted instructions.

Behaviour:
- Reset (asynchronous assert, synchronous release): rf_we=0, rf_wa=0, rf_wd=0, flags=8'h00, retired=0, fwd_valid=0.
- Accept condition: acc = in_valid & in_ready.
- in_ready = !rf_we | rf_ready. in_ready is combinational and does not depend on in_valid.
- Holding-register states:
  - EMPTY: rf_we=0.
  - FULL: rf_we=1.
- Transitions:
  - EMPTY -> FULL on acc & in_wb_en.
  - FULL -> EMPTY on rf_ready & !(acc & in_wb_en).
  - FULL stays FULL on rf_ready & acc & in_wb_en; the register reloads with the new data in the same cycle.
  - FULL with !rf_ready holds; rf_wa and rf_wd stay stable, and in_ready=0.
- Accepted entries with in_wb_en=0 (CMP, TEST, BTST, SEC/CLC) never load the holding register but still retire and may update flags.
- Latency: result visible on rf_* one cycle after acc; rf_* stays valid until rf_ready.
- Flag register, priority highest first:
  1. flag_ld: flags <= flag_ld_val.
  2. acc & in_flag_en: flags <= in_fo.
  3. Otherwise hold.
  - flag_ld wins even if acc & in_flag_en occur in the same cycle.
  - The instruction in that case still retires and still writes its result.
- Flags update at acceptance, not at register-file commit. In-order flag consumption is therefore independent of rf back-pressure.
- Forwarding: fwd_valid=rf_we, fwd_rd=rf_wa, fwd_data=rf_wd, all pure wires. A same-cycle acc is not forwarded.
- retired increments by 1 on every acc and wraps from all-ones to 0 silently.
- Reset mid-stall discards the pending write; nothing is written after reset release until a new acc.

Optional Feature:
- Macro: ALU2_WB_FLAG_BYPASS_EN.
- Defined: flags output = in_fo when (acc & in_flag_en & !flag_ld), else the flag register. A back-to-back ALU op sees the new flags in the same cycle as the producer (combinational path in_valid -> flags).
- Undefined: flags is the registered value only, so there is one cycle of flag latency. The decoder must insert a bubble between a flag producer and an ADC, SBB, ROR or ROL consumer.

Decomposition:
- Flag bit indices (CIDX, VIDX, ZIDX, SIDX, PIDX, UIDX, N1IDX, N2IDX) come from the shared defs.v include. No new typedefs.
- Holding-register state encoding: one bit (rf_we itself); no package constant is needed.
- One sub-module, alu2_flagreg: the 8-bit flag register with load priority and the optional bypass mux.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> rf_we=0, flags=8'h00, retired=0. First acc after release with in_res=32'h1234_5678, in_rd=3, wb_en=1 -> next cycle rf_we=1, rf_wa=3, rf_wd=32'h1234_5678.
- Back-pressure: rf_ready=0 for 3 cycles while FULL -> in_ready=0, rf_wd stable, retired unchanged. rf_ready=1 with a new acc (rd=5, res=32'hA5) -> register reloads with no bubble, and retired increments by 1.
- Flag-only op: acc with wb_en=0, flag_en=1, in_fo=8'h03 -> flags=8'h03 next cycle, rf_we stays 0, retired increments.
- Priority: same cycle flag_ld=1 (val=8'hF0) and acc with flag_en=1 (fo=8'h01) -> flags=8'hF0.
- Counter wrap: force retired to 32'hFFFF_FFFF, then one acc -> retired=0.
- Bypass (macro defined): acc with flag_en=1, fo=8'h01 -> flags=8'h01 in the same cycle. Without the macro, flags=8'h01 only on the next cycle.
